// File: rtl/instruction_memory_sync_if.sv
// instruction_memory_sync_if: fetch and load bus of the instruction memory; master = CPU/bootloader side, slave = memory
interface instruction_memory_sync_if #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 16
);
  logic                  rd_enable;
  logic [ADDR_WIDTH-1:0] address;
  logic                  stall;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  valid;
  logic                  out_of_range;
  logic                  wr_enable;
  logic [ADDR_WIDTH-1:0] wr_address;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_error;
  logic [ADDR_WIDTH:0]   loaded_count;
  modport master(
    output rd_enable, address, stall, wr_enable, wr_address, wr_data,
    input  instruction, valid, out_of_range, wr_error, loaded_count
  );
  modport slave(
    input  rd_enable, address, stall, wr_enable, wr_address, wr_data,
    output instruction, valid, out_of_range, wr_error, loaded_count
  );
endinterface

// File: rtl/instruction_memory_sync.sv
// instruction_memory_sync: loadable synchronous instruction memory; ports: clk, rst (async high), bus (slave: fetch rd_enable/address/stall -> instruction/valid/out_of_range, load wr_enable/wr_address/wr_data -> wr_error/loaded_count)
module instruction_memory_sync #(
  parameter int                    DATA_WIDTH   = 28,
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DEPTH        = 256,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = 28'h00000AA
) (
  input logic clk,
  input logic rst,
  instruction_memory_sync_if.slave bus
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] loaded;
  logic rd_in, wr_in, wr_ok, rd_ok;
  logic [IW-1:0] ri, wi;
  logic [DATA_WIDTH-1:0] rd_word;
  assign rd_in = {1'b0, bus.address} < DEPTH_A;
  assign wr_in = {1'b0, bus.wr_address} < DEPTH_A;
  assign ri = IW'(bus.address);
  assign wi = IW'(bus.wr_address);
  assign wr_ok = bus.wr_enable && wr_in && !rst;
  assign rd_ok = bus.rd_enable && !bus.stall;
  // write-first: a load to the address being fetched in the same cycle is returned directly
  always_comb
    rd_word = (wr_ok && rd_in && bus.wr_address == bus.address) ? bus.wr_data :
              (rd_in && loaded[ri]) ? mem[ri] : DEFAULT_WORD;
  always_ff @(posedge clk)
    if (wr_ok) mem[wi] <= bus.wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      loaded           <= '0;
      bus.loaded_count <= '0;
      bus.wr_error     <= 1'b0;
      bus.instruction  <= DEFAULT_WORD;
      bus.valid        <= 1'b0;
      bus.out_of_range <= 1'b0;
    end else begin
      bus.wr_error <= bus.wr_enable && !wr_in;
      if (wr_ok) begin
        loaded[wi] <= 1'b1;
        if (!loaded[wi]) bus.loaded_count <= bus.loaded_count + 1'b1;
      end
      if (rd_ok) begin
        bus.instruction  <= rd_word;
        bus.valid        <= 1'b1;
        bus.out_of_range <= !rd_in;
      end else if (!bus.stall) bus.valid <= 1'b0;
    end
endmodule
